// File: rtl/ex_div_if.sv
// ex_div_if -- handshake/data bundle between the EX stage and the divider.
//   start_i   : divide request, held high until the result is taken
//   signed_i  : 1 = two's-complement divide, 0 = unsigned
//   annul_i   : pipeline flush, abandons the current divide
//   opdata1_i : dividend
//   opdata2_i : divisor
//   result_o  : {remainder, quotient} (HI/LO)
//   ready_o   : result_o valid
//   busy_o    : divide in progress (EX stall request)
// master = EX stage, slave = divider.
interface ex_div_if;
    logic        start_i;
    logic        signed_i;
    logic        annul_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    modport master (
        output start_i,
        output signed_i,
        output annul_i,
        output opdata1_i,
        output opdata2_i,
        input  result_o,
        input  ready_o,
        input  busy_o
    );

    modport slave (
        input  start_i,
        input  signed_i,
        input  annul_i,
        input  opdata1_i,
        input  opdata2_i,
        output result_o,
        output ready_o,
        output busy_o
    );
endinterface

// File: rtl/ex_div.sv
// ex_div -- 32-bit iterative restoring divider for the EX stage.
// One shift-subtract step per cycle on operand magnitudes, sign-corrected at the end.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : ex_div_if slave (start/signed/annul/operands in, result/ready/busy out)
module ex_div (
    input  logic     clk,
    input  logic     rst,
    ex_div_if.slave  bus
);

    localparam logic [1:0] ST_FREE    = 2'd0;
    localparam logic [1:0] ST_BY_ZERO = 2'd1;
    localparam logic [1:0] ST_ON      = 2'd2;
    localparam logic [1:0] ST_END     = 2'd3;

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [32:0] r_rem;     // partial remainder
    logic [31:0] r_quo;     // dividend shifts out the top, quotient bits shift in at the bottom
    logic [31:0] r_dvs;     // divisor magnitude
    logic        r_neg_q;
    logic        r_neg_r;
    logic [63:0] r_result;
    logic        r_ready;

    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [33:0] w_shift;
    logic [33:0] w_diff;
    logic        w_fit;
    logic [32:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    always_comb begin
        // Magnitudes; 0x80000000 negates to itself, which is the correct unsigned magnitude.
        w_mag1 = (bus.signed_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
        w_mag2 = (bus.signed_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

        // r_rem < r_dvs always holds, so the shifted value stays below 2^33 and
        // bit 33 of the difference is a clean borrow flag.
        w_shift    = {r_rem, r_quo[31]};
        w_diff     = w_shift - {2'b00, r_dvs};
        w_fit      = ~w_diff[33];
        w_rem_next = w_fit ? w_diff[32:0] : w_shift[32:0];
        w_quo_next = {r_quo[30:0], w_fit};

        w_quo_fix  = r_neg_q ? (~r_quo + 32'd1) : r_quo;
        w_rem_fix  = r_neg_r ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_FREE;
            r_cnt    <= 6'd0;
            r_rem    <= 33'd0;
            r_quo    <= 32'd0;
            r_dvs    <= 32'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= 64'd0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                ST_FREE: begin
                    r_result <= 64'd0;
                    r_ready  <= 1'b0;
                    if (bus.start_i && !bus.annul_i) begin
                        r_neg_q <= bus.signed_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                        r_neg_r <= bus.signed_i & bus.opdata1_i[31];
                        r_dvs   <= w_mag2;
                        r_cnt   <= 6'd0;
                        r_rem   <= 33'd0;
                        if (bus.opdata2_i == 32'd0) begin
                            // Raw dividend is kept; it becomes the HI half of the result.
                            r_quo   <= bus.opdata1_i;
                            r_state <= ST_BY_ZERO;
                        end else begin
                            r_quo   <= w_mag1;
                            r_state <= ST_ON;
                        end
                    end
                end
                ST_BY_ZERO: begin
                    if (bus.annul_i) begin
                        r_state <= ST_FREE;
                    end else begin
                        r_state  <= ST_END;
                        r_result <= {r_quo, 32'hFFFF_FFFF};
                        r_ready  <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (bus.annul_i) begin
                        r_state <= ST_FREE;
                        r_cnt   <= 6'd0;
                        r_rem   <= 33'd0;
                    end else if (r_cnt == 6'd32) begin
                        r_state  <= ST_END;
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_ready  <= 1'b1;
                        r_cnt    <= 6'd0;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                ST_END: begin
                    if (bus.annul_i || !bus.start_i) begin
                        r_state  <= ST_FREE;
                        r_result <= 64'd0;
                        r_ready  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_FREE;
                    r_result <= 64'd0;
                    r_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;
    assign bus.busy_o   = (r_state == ST_ON) || (r_state == ST_BY_ZERO);

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  reset; asynchronous, active-low (asserted at 0).
REQ-003 SHALL have port: start_i  input  1  EX-stage divide request; held high until result taken.
REQ-004 SHALL have port: signed_i  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-005 SHALL have port: annul_i  input  1  pipeline flush; abandons current divide.
REQ-006 SHALL have port: opdata1_i  input  32  dividend.
REQ-007 SHALL have port: opdata2_i  input  32  divisor.
REQ-008 SHALL have port: result_o  output  64  {remainder[63:32], quotient[31:0]} (HI/LO).
REQ-009 SHALL have port: ready_o  output  1  result_o valid.
REQ-010 SHALL have port: busy_o  output  1  divide in progress; EX uses it as stall request.

Function
REQ-011 SHALL implement states FREE, BY_ZERO, ON, END.
REQ-012 FREE: start_i=1 and annul_i=0 at an edge SHALL latch signed_i, opdata1_i and opdata2_i; go to BY_ZERO if opdata2_i==0, else ON with the iteration counter cleared.
REQ-013 FREE with annul_i=1 SHALL ignore start_i and stay in FREE.
REQ-014 In signed mode, operands SHALL be converted to magnitudes at latch time; 0x80000000 maps to unsigned 0x80000000.
REQ-015 ON SHALL perform one restoring shift-subtract step per cycle, 32 steps, using a 33-bit partial remainder and a 6-bit counter.
REQ-016 After step 32 the next edge SHALL enter END and register the corrected result.
REQ-017 Total latency: ready_o SHALL rise exactly 33 clock edges after the accepting edge.
REQ-018 Sign correction: quotient SHALL be negated when latched operand signs differ (signed mode only); remainder SHALL take the dividend's sign; all arithmetic mod 2^32.
REQ-019 BY_ZERO SHALL go to END on the next edge with result_o = {latched dividend, 32'hFFFF_FFFF}, so ready_o rises 2 edges after acceptance.
REQ-020 END SHALL hold ready_o=1 and result_o stable while start_i=1 and annul_i=0.
REQ-021 END with start_i=0 SHALL go to FREE on the next edge, with ready_o=0 and result_o=0.
REQ-022 annul_i=1 in ON, BY_ZERO or END SHALL go to FREE on the next edge, with ready_o=0 and result_o=0; partial work is discarded.
REQ-023 Operand and signed_i changes after acceptance SHALL NOT affect the running divide.
REQ-024 busy_o SHALL be 1 in BY_ZERO and ON, and 0 in FREE and END.
REQ-025 result_o SHALL be 0 in every state except END.

Reset
REQ-026 rst=0 SHALL immediately, without a clock edge, force state=FREE, counter=0, partial remainder=0, result_o=0, ready_o=0 and busy_o=0, including mid-divide.
REQ-027 After rst returns to 1, the first edge with start_i=1 and annul_i=0 SHALL be accepted normally.

Verification
REQ-028 Unsigned 100/7, start_i held -> ready_o at edge 33 after acceptance; result_o = {32'd2, 32'd14}; busy_o=1 for exactly 33 cycles.
REQ-029 Signed -7/2 (0xFFFFFFF9/0x00000002) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}; signed 7/-2 -> {0x00000001, 0xFFFFFFFD}.
REQ-030 Signed 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}; the same operands unsigned -> {0x80000000, 0x00000000}.
REQ-031 5/0 (either mode) -> ready_o 2 edges after acceptance; result_o = {0x00000005, 0xFFFFFFFF}.
REQ-032 annul_i pulsed 10 cycles into ON -> FREE next edge; ready_o never asserts; a new 9/3 start is then accepted -> {0, 3} after 33 edges.
REQ-033 rst=0 asserted asynchronously mid-ON -> busy_o, ready_o and result_o go to 0 before the next clock edge; dropping start_i in END -> FREE next edge with ready_o=0.
